fifo_3x3: RTL and testbench

Streaming 3x3 sliding-window generator for raster-scan pixel data in the sensor pre-processing path. Each accepted pixel shifts into a 3x3 window built from two internal line buffers, so the window holds the current and two previous image lines. It feeds 3x3 neighbourhood filters (erosion/dilation, convolution). It takes one pixel per enabled clock and has no frame-sync input.

---
 rtl/fifo_3x3_pkg.sv | 18 +
 rtl/fifo_3x3_line_buffer.sv | 28 ++
 rtl/fifo_3x3.sv | 144 ++++++++++++++
 tb/tb_fifo_3x3.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/fifo_3x3_pkg.sv
// Shared types and sizing helpers for the 3x3 sliding-window generator.
// Column counters and line-buffer addresses are sized from MAX_WIDTH.
package fifo_3x3_pkg;

  localparam int MAX_WIDTH_DEF = 2048;

  function automatic int col_aw(input int max_width);
    return (max_width > 2) ? $clog2(max_width) : 1;
  endfunction

  localparam int COL_AW = col_aw(MAX_WIDTH_DEF);

  typedef logic [COL_AW-1:0] col_t;
  typedef logic [1:0]        row_t;

  localparam row_t ROW_LAST = 2'd2;

endpackage

// File: rtl/fifo_3x3_line_buffer.sv
// Single-port line buffer: asynchronous read of the addressed entry and a
// synchronous write to the same entry, giving read-before-write per edge.
module fifo_3x3_line_buffer
  import fifo_3x3_pkg::*;
#(
  parameter int N     = 1,
  parameter int DEPTH = MAX_WIDTH_DEF,
  parameter int AW    = col_aw(DEPTH)
) (
  input  logic          clock,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [N-1:0]  wr_data,
  output logic [N-1:0]  rd_data
);

  // Contents are deliberately not reset; the valid logic never exposes stale lines.
  logic [N-1:0] mem_q [DEPTH];

  assign rd_data = mem_q[addr];

  always_ff @(posedge clock) begin
    if (we) begin
      mem_q[addr] <= wr_data;
    end
  end

endmodule

// File: rtl/fifo_3x3.sv
// 3x3 sliding-window generator over raster-scan pixels using two line buffers.
// Build option FIFO_3X3_EDGE_MASK_EN suppresses windows straddling a line wrap.
module fifo_3x3
  import fifo_3x3_pkg::*;
#(
  parameter int N         = 1,
  parameter int MAX_WIDTH = MAX_WIDTH_DEF
) (
  input  logic         clock,
  input  logic         reset_n,
  input  logic [15:0]  width,
  input  logic         read,
  input  logic [N-1:0] pi,
  output logic [N-1:0] po00,
  output logic [N-1:0] po01,
  output logic [N-1:0] po02,
  output logic [N-1:0] po10,
  output logic [N-1:0] po11,
  output logic [N-1:0] po12,
  output logic [N-1:0] po20,
  output logic [N-1:0] po21,
  output logic [N-1:0] po22,
  output logic         valid
);

  localparam int AW = col_aw(MAX_WIDTH);

  logic [AW-1:0] col_q, col_d;
  row_t          row_q, row_d;
  logic          valid_q, valid_d;
  logic [N-1:0]  win_q [3][3];
  logic [N-1:0]  win_d [3][3];

  logic [15:0]   col_ext;
  logic          width_ok;
  logic          window_full;
  logic          lb_we;
  logic [N-1:0]  lb_a_rd;
  logic [N-1:0]  lb_b_rd;

  assign col_ext     = 16'(col_q);
  assign width_ok    = (width >= 16'd3);
  assign window_full = (row_q == ROW_LAST) && (col_ext >= 16'd2);
  assign lb_we       = read & reset_n;

  fifo_3x3_line_buffer #(
    .N     (N),
    .DEPTH (MAX_WIDTH),
    .AW    (AW)
  ) u_lb_a (
    .clock   (clock),
    .we      (lb_we),
    .addr    (col_q),
    .wr_data (pi),
    .rd_data (lb_a_rd)
  );

  // Line B is fed from line A's old output, so it lags one more line.
  fifo_3x3_line_buffer #(
    .N     (N),
    .DEPTH (MAX_WIDTH),
    .AW    (AW)
  ) u_lb_b (
    .clock   (clock),
    .we      (lb_we),
    .addr    (col_q),
    .wr_data (lb_a_rd),
    .rd_data (lb_b_rd)
  );

`ifdef FIFO_3X3_EDGE_MASK_EN
  always_comb begin
    valid_d = read && width_ok && window_full;
  end
`else
  // Once the first full window is seen, wrap-around windows are also flagged.
  logic primed_q, primed_d;

  always_comb begin
    primed_d = primed_q | (read && width_ok && window_full);
    valid_d  = read && width_ok && (row_q == ROW_LAST) &&
               ((col_ext >= 16'd2) || primed_q);
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      primed_q <= 1'b0;
    end else begin
      primed_q <= primed_d;
    end
  end
`endif

  always_comb begin
    col_d = col_q;
    row_d = row_q;
    win_d = win_q;
    if (read) begin
      if (col_ext == width - 16'd1) begin
        col_d = '0;
        row_d = (row_q == ROW_LAST) ? ROW_LAST : row_q + 2'd1;
      end else begin
        col_d = col_q + AW'(1);
      end
      for (int r = 0; r < 3; r++) begin
        win_d[r][0] = win_q[r][1];
        win_d[r][1] = win_q[r][2];
      end
      win_d[2][2] = pi;
      win_d[1][2] = lb_a_rd;
      win_d[0][2] = lb_b_rd;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      col_q   <= '0;
      row_q   <= '0;
      valid_q <= 1'b0;
      for (int r = 0; r < 3; r++) begin
        for (int c = 0; c < 3; c++) begin
          win_q[r][c] <= '0;
        end
      end
    end else begin
      col_q   <= col_d;
      row_q   <= row_d;
      valid_q <= valid_d;
      win_q   <= win_d;
    end
  end

  assign po00  = win_q[0][0];
  assign po01  = win_q[0][1];
  assign po02  = win_q[0][2];
  assign po10  = win_q[1][0];
  assign po11  = win_q[1][1];
  assign po12  = win_q[1][2];
  assign po20  = win_q[2][0];
  assign po21  = win_q[2][1];
  assign po22  = win_q[2][2];
  assign valid = valid_q;

endmodule

// File: tb/tb_fifo_3x3.sv
// Bench for fifo_3x3: an 8-bit/width-8 instance and a 1-bit instance for
// width 3 and width 2; expectations come from a pixel-history model.
module tb_fifo_3x3;

  logic clock = 1'b0;
  initial forever #5 clock = ~clock;

  logic        reset_n_a, read_a;
  logic [15:0] width_a;
  logic [7:0]  pi_a;
  logic [7:0]  a00, a01, a02, a10, a11, a12, a20, a21, a22;
  logic        valid_a;

  logic        reset_n_b, read_b;
  logic [15:0] width_b;
  logic        pi_b;
  logic        b00, b01, b02, b10, b11, b12, b20, b21, b22;
  logic        valid_b;

  fifo_3x3 #(.N(8), .MAX_WIDTH(2048)) u_dut_a (
    .clock(clock), .reset_n(reset_n_a), .width(width_a), .read(read_a), .pi(pi_a),
    .po00(a00), .po01(a01), .po02(a02), .po10(a10), .po11(a11), .po12(a12),
    .po20(a20), .po21(a21), .po22(a22), .valid(valid_a)
  );

  fifo_3x3 #(.N(1), .MAX_WIDTH(16)) u_dut_b (
    .clock(clock), .reset_n(reset_n_b), .width(width_b), .read(read_b), .pi(pi_b),
    .po00(b00), .po01(b01), .po02(b02), .po10(b10), .po11(b11), .po12(b12),
    .po20(b20), .po21(b21), .po22(b22), .valid(valid_b)
  );

  logic [71:0] obs_win_a, obs_win_b;
  assign obs_win_a = {a00, a01, a02, a10, a11, a12, a20, a21, a22};
  assign obs_win_b = {7'd0, b00, 7'd0, b01, 7'd0, b02, 7'd0, b10, 7'd0, b11,
                      7'd0, b12, 7'd0, b20, 7'd0, b21, 7'd0, b22};

  // Scoreboard entry: {check_window, expected_valid, expected_window}
  logic [73:0] exp_q[$];

  int          n_cmp;
  int          n_err;
  int          sel;
  int          w_m;
  logic [7:0]  hist[$];
  logic [71:0] last_win;
  logic        have_win;

  task automatic check_eq(input string tag, input logic [71:0] obs, input logic [71:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_push(input logic rd, input logic [7:0] px, input logic rst);
    logic        v;
    logic        cw;
    logic [71:0] win;
    int          i;
    v   = 1'b0;
    cw  = 1'b0;
    win = '0;
    if (rst) begin
      hist.delete();
      cw       = 1'b1;
      last_win = '0;
      have_win = 1'b1;
    end else if (rd) begin
      hist.push_back(px);
      i = hist.size() - 1;
      v = (w_m >= 3) && (i >= 2 * w_m + 2);
`ifdef FIFO_3X3_EDGE_MASK_EN
      if ((w_m > 0) && ((i % w_m) < 2)) v = 1'b0;
`endif
      if (v) begin
        for (int r = 0; r < 3; r++) begin
          for (int c = 0; c < 3; c++) begin
            win[71 - 8 * (r * 3 + c) -: 8] = hist[i - (2 - r) * w_m - (2 - c)];
          end
        end
        cw       = 1'b1;
        last_win = win;
        have_win = 1'b1;
      end else begin
        have_win = 1'b0;
      end
    end else begin
      cw  = have_win;
      win = last_win;
    end
    exp_q.push_back({cw, v, win});
  endtask

  task automatic step(input logic rd, input logic [7:0] px, input logic rst);
    logic [73:0] e;
    logic        obs_v;
    logic [71:0] obs_w;
    if (sel == 0) begin
      read_a = rd; pi_a = px; reset_n_a = ~rst;
      model_push(rd, px, rst);
    end else begin
      read_b = rd; pi_b = px[0]; reset_n_b = ~rst;
      model_push(rd, {7'd0, px[0]}, rst);
    end
    @(posedge clock);
    @(negedge clock);
    read_a = 1'b0; read_b = 1'b0; reset_n_a = 1'b1; reset_n_b = 1'b1;
    obs_v = (sel == 0) ? valid_a : valid_b;
    obs_w = (sel == 0) ? obs_win_a : obs_win_b;
    if (exp_q.size() == 0) begin
      n_cmp++;
      n_err++;
      $display("FAIL sb_empty: got no expected entry, required one");
    end else begin
      e = exp_q.pop_front();
      check_eq("valid", {71'd0, obs_v}, {71'd0, e[72]});
      if (e[73]) check_eq("window", obs_w, e[71:0]);
    end
  endtask

  initial begin
    int nv;
    n_cmp = 0; n_err = 0; sel = 0; w_m = 8; have_win = 1'b0; last_win = '0;
    width_a = 16'd8; width_b = 16'd3;
    reset_n_a = 1'b0; read_a = 1'b0; pi_a = '0;
    reset_n_b = 1'b0; read_b = 1'b0; pi_b = 1'b0;
    @(negedge clock);

    step(1'b1, 8'hFF, 1'b1);
    check_eq("reset_win", obs_win_a, 72'd0);

    for (int p = 1; p <= 20; p++) begin
      step(1'b1, 8'(p), 1'b0);
      if (p == 19) begin
        check_eq("p19_valid", {71'd0, valid_a}, 72'd1);
        check_eq("p19_win", obs_win_a,
                 {8'd1, 8'd2, 8'd3, 8'd9, 8'd10, 8'd11, 8'd17, 8'd18, 8'd19});
      end
    end

    repeat (5) step(1'b0, 8'hAA, 1'b0);
    check_eq("stall_row2", {48'd0, obs_win_a[23:0]}, {48'd0, 8'd18, 8'd19, 8'd20});

    for (int p = 21; p <= 30; p++) begin
      step(1'b1, 8'(p), 1'b0);
      if (p == 21) check_eq("resume_po22", {64'd0, a22}, 72'd21);
`ifdef FIFO_3X3_EDGE_MASK_EN
      if (p == 25) check_eq("p25_masked", {71'd0, valid_a}, 72'd0);
      if (p == 27) check_eq("p27_win", obs_win_a,
                            {8'd9, 8'd10, 8'd11, 8'd17, 8'd18, 8'd19, 8'd25, 8'd26, 8'd27});
`else
      if (p == 25) check_eq("p25_win", obs_win_a,
                            {8'd7, 8'd8, 8'd9, 8'd15, 8'd16, 8'd17, 8'd23, 8'd24, 8'd25});
`endif
    end

    repeat (80) step($urandom_range(0, 3) != 0, 8'($urandom_range(0, 255)), 1'b0);

    step(1'b0, 8'h00, 1'b1);
    for (int p = 1; p <= 22; p++) step(1'b1, 8'(p), 1'b0);
    step(1'b1, 8'h55, 1'b1);
    check_eq("midreset_win", obs_win_a, 72'd0);
    for (int p = 1; p <= 20; p++) begin
      step(1'b1, 8'(p), 1'b0);
      if (p == 18) check_eq("restart_p18", {71'd0, valid_a}, 72'd0);
      if (p == 19) check_eq("restart_p19", {71'd0, valid_a}, 72'd1);
    end

    sel = 1; w_m = 3;
    step(1'b0, 8'h00, 1'b1);
    nv = 0;
    for (int k = 0; k < 30; k++) begin
      step(1'b1, 8'(k % 2), 1'b0);
      if (k == 8) check_eq("w3_first", {71'd0, valid_b}, 72'd1);
      if (k >= 9 && k <= 26 && valid_b) nv++;
    end
`ifdef FIFO_3X3_EDGE_MASK_EN
    check_eq("w3_per_line", 72'(nv), 72'd6);
`else
    check_eq("w3_per_line", 72'(nv), 72'd18);
`endif

    width_b = 16'd2; w_m = 2;
    step(1'b0, 8'h00, 1'b1);
    repeat (14) step(1'b1, 8'($urandom_range(0, 1)), 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
